hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_match.sv | 19 +
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared entry record and default sizes for the hazard scoreboard
package hazard_pkg;

   // Default register-specifier width and number of tracked stages past ID.
   localparam int HZ_REG_W = 3;
   localparam int HZ_DEPTH = 3;

   // Destination field is sized for the widest supported register file (REG_W <= 8);
   // narrower specifiers are zero-extended so compares stay exact.
   localparam int HZ_DEST_MAX_W = 8;

   typedef struct packed {
      logic                     valid;
      logic                     wr;
      logic [HZ_DEST_MAX_W-1:0] dest;
      logic                     load;
   } hz_entry_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - single-stage RAW compare of one shadow entry against the ID sources
module hazard_match
   import hazard_pkg::*;
(
   input  hz_entry_t                entry,
   input  logic [HZ_DEST_MAX_W-1:0] src_a,
   input  logic [HZ_DEST_MAX_W-1:0] src_b,
   input  logic                     use_a,
   input  logic                     use_b,
   output logic                     hit
);

   // A live register write whose destination is read by ID through an enabled source.
   always_comb begin
      hit = entry.valid & entry.wr &
            ((use_a & (entry.dest == src_a)) | (use_b & (entry.dest == src_b)));
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow-pipe RAW hazard detector with stall control and stall counter
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W       = HZ_REG_W,
   parameter int DEPTH       = HZ_DEPTH,
   parameter int FLUSH_DEPTH = 0,
   parameter int RF_BYPASS   = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic             id_writeReg,
   input  logic [REG_W-1:0] id_writeSel,
   input  logic             id_isLoad,
   input  logic [REG_W-1:0] readReg1_IFID,
   input  logic [REG_W-1:0] readReg2_IFID,
   input  logic             useA,
   input  logic             useB,
   input  logic             fwd_en,
   input  logic             flush,
   input  logic             clr_count,
   output logic             stall,
   output logic             enPC,
   output logic             enIFID,
   output logic             bubble_IDEX,
   output logic [CNT_W-1:0] stall_count
);

   // With a write-before-read register file the WB stage resolves itself.
   localparam int CMP_DEPTH = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

   hz_entry_t              pipe_q [1:DEPTH];
   hz_entry_t              pipe_d [1:DEPTH];
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [DEPTH:1]         hit;
   logic [DEPTH:1]         cmp_mask;
   logic [HZ_DEST_MAX_W-1:0] src_a;
   logic [HZ_DEST_MAX_W-1:0] src_b;
   logic                   any_hit;
   logic                   load_use;

   assign src_a = HZ_DEST_MAX_W'(readReg1_IFID);
   assign src_b = HZ_DEST_MAX_W'(readReg2_IFID);

   for (genvar k = 1; k <= DEPTH; k++) begin : g_match
      hazard_match u_match (
         .entry (pipe_q[k]),
         .src_a (src_a),
         .src_b (src_b),
         .use_a (useA),
         .use_b (useB),
         .hit   (hit[k])
      );
   end

   // Stall decision: any live producer without forwarding, only load-use in EX with forwarding.
   always_comb begin
      for (int k = 1; k <= DEPTH; k++) begin
         cmp_mask[k] = (k <= CMP_DEPTH);
      end
      any_hit     = |(hit & cmp_mask);
      load_use    = hit[1] & cmp_mask[1] & pipe_q[1].load;
      stall       = id_valid & ~flush & (fwd_en ? load_use : any_hit);
      enPC        = ~stall;
      enIFID      = ~stall;
      bubble_IDEX = stall | flush;
   end

   // Next shadow pipe: issue or bubble into EX; flush kills the youngest FLUSH_DEPTH entries.
   always_comb begin
      pipe_d[1] = '0;
      if (id_valid && !stall && !flush) begin
         pipe_d[1].valid = 1'b1;
         pipe_d[1].wr    = id_writeReg;
         pipe_d[1].dest  = HZ_DEST_MAX_W'(id_writeSel);
         pipe_d[1].load  = id_isLoad;
      end
      for (int k = 2; k <= DEPTH; k++) begin
         if (flush && ((k - 1) <= FLUSH_DEPTH)) begin
            pipe_d[k] = '0;
         end else begin
            pipe_d[k] = pipe_q[k-1];
         end
      end
   end

   // Saturating stall counter; a clear request overrides a same-cycle stall.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_count) begin
         cnt_d = '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign stall_count = cnt_q;

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= DEPTH; k++) begin
            pipe_q[k] <= '0;
         end
         cnt_q <= '0;
      end else begin
         for (int k = 1; k <= DEPTH; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic       id_writeReg;
   logic [2:0] id_writeSel;
   logic       id_isLoad;
   logic [2:0] readReg1_IFID;
   logic [2:0] readReg2_IFID;
   logic       useA;
   logic       useB;
   logic       fwd_en;
   logic       flush;
   logic       clr_count;

   logic        stall_a, enpc_a, enifid_a, bub_a;
   logic [15:0] cnt_a;
   logic        stall_b, enpc_b, enifid_b, bub_b;
   logic [15:0] cnt_b;
   logic        stall_c, enpc_c, enifid_c, bub_c;
   logic [3:0]  cnt_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard u_dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_writeReg(id_writeReg),
      .id_writeSel(id_writeSel), .id_isLoad(id_isLoad),
      .readReg1_IFID(readReg1_IFID), .readReg2_IFID(readReg2_IFID),
      .useA(useA), .useB(useB), .fwd_en(fwd_en), .flush(flush), .clr_count(clr_count),
      .stall(stall_a), .enPC(enpc_a), .enIFID(enifid_a), .bubble_IDEX(bub_a),
      .stall_count(cnt_a)
   );

   hazard_scoreboard #(.RF_BYPASS(1)) u_dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_writeReg(id_writeReg),
      .id_writeSel(id_writeSel), .id_isLoad(id_isLoad),
      .readReg1_IFID(readReg1_IFID), .readReg2_IFID(readReg2_IFID),
      .useA(useA), .useB(useB), .fwd_en(fwd_en), .flush(flush), .clr_count(clr_count),
      .stall(stall_b), .enPC(enpc_b), .enIFID(enifid_b), .bubble_IDEX(bub_b),
      .stall_count(cnt_b)
   );

   hazard_scoreboard #(.FLUSH_DEPTH(1), .CNT_W(4)) u_dut_c (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_writeReg(id_writeReg),
      .id_writeSel(id_writeSel), .id_isLoad(id_isLoad),
      .readReg1_IFID(readReg1_IFID), .readReg2_IFID(readReg2_IFID),
      .useA(useA), .useB(useB), .fwd_en(fwd_en), .flush(flush), .clr_count(clr_count),
      .stall(stall_c), .enPC(enpc_c), .enIFID(enifid_c), .bubble_IDEX(bub_c),
      .stall_count(cnt_c)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One cycle: advance past the edge, apply this cycle's inputs, let them settle.
   task automatic cyc(input logic v, input logic wr, input logic [2:0] ws, input logic ld,
                      input logic [2:0] r1, input logic [2:0] r2, input logic ua, input logic ub,
                      input logic clr, input logic fl);
      @(posedge clk);
      #1;
      id_valid = v; id_writeReg = wr; id_writeSel = ws; id_isLoad = ld;
      readReg1_IFID = r1; readReg2_IFID = r2; useA = ua; useB = ub;
      clr_count = clr; flush = fl;
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wr_cyc(input logic [2:0] ws, input logic ld, input logic clr);
      cyc(1'b1, 1'b1, ws, ld, 3'd0, 3'd0, 1'b0, 1'b0, clr, 1'b0);
   endtask

   task automatic rd_cyc(input logic [2:0] r1, input logic [2:0] r2, input logic ua,
                         input logic ub, input logic clr, input logic fl);
      cyc(1'b1, 1'b0, 3'd0, 1'b0, r1, r2, ua, ub, clr, fl);
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_writeReg = 1'b0; id_writeSel = '0; id_isLoad = 1'b0;
      readReg1_IFID = '0; readReg2_IFID = '0; useA = 1'b0; useB = 1'b0;
      fwd_en = 1'b0; flush = 1'b0; clr_count = 1'b0;

      // Reset state, outputs evaluated from the cleared state while rst is high.
      idle();
      idle();
      chk("rst_stall", stall_a, 0);
      chk("rst_enpc", enpc_a, 1);
      chk("rst_enifid", enifid_a, 1);
      chk("rst_bubble", bub_a, 0);
      chk("rst_count", cnt_a, 0);
      flush = 1'b1;
      #1;
      chk("rst_bubble_flush", bub_a, 1);
      flush = 1'b0;
      rst = 1'b0;
      idle();

      // No forwarding: write r3, then read r3.
      wr_cyc(3'd3, 1'b0, 1'b1);
      chk("nofwd_c0_stall", stall_a, 0);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nofwd_c1_stall", stall_a, 1);
      chk("nofwd_c1_enpc", enpc_a, 0);
      chk("nofwd_c1_bubble", bub_a, 1);
      chk("byp_c1_stall", stall_b, 1);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nofwd_c2_stall", stall_a, 1);
      chk("byp_c2_stall", stall_b, 1);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nofwd_c3_stall", stall_a, 1);
      chk("byp_c3_stall", stall_b, 0);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("nofwd_c4_stall", stall_a, 0);
      chk("nofwd_count", cnt_a, 3);
      chk("byp_count", cnt_b, 2);
      for (int i = 0; i < 4; i++) idle();

      // Forwarding: load-use stalls one cycle; ALU producer does not stall.
      fwd_en = 1'b1;
      wr_cyc(3'd5, 1'b1, 1'b1);
      chk("fwd_ld_c0_stall", stall_a, 0);
      rd_cyc(3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fwd_ld_c1_stall", stall_a, 1);
      rd_cyc(3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fwd_ld_c2_stall", stall_a, 0);
      idle();
      chk("fwd_ld_count", cnt_a, 1);
      wr_cyc(3'd5, 1'b0, 1'b0);
      rd_cyc(3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fwd_alu_stall", stall_a, 0);
      for (int i = 0; i < 4; i++) idle();

      // Unused source does not stall; both sources matching gives one stall per cycle.
      fwd_en = 1'b0;
      wr_cyc(3'd4, 1'b0, 1'b1);
      rd_cyc(3'd6, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("useb_off_stall", stall_a, 0);
      rd_cyc(3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("both_src_stall", stall_a, 1);
      rd_cyc(3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("both_src_stall2", stall_a, 1);
      chk("both_src_count1", cnt_a, 1);
      rd_cyc(3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("both_src_stall3", stall_a, 0);
      chk("both_src_count2", cnt_a, 2);
      for (int i = 0; i < 4; i++) idle();

      // Flush kills the r2 writer in EX (FLUSH_DEPTH=1) and dominates stall.
      wr_cyc(3'd2, 1'b0, 1'b1);
      rd_cyc(3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("flush_stall", stall_c, 0);
      chk("flush_bubble", bub_c, 1);
      chk("flush_stall_fd0", stall_a, 0);
      rd_cyc(3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_flush_stall", stall_c, 0);
      chk("post_flush_fd0_stall", stall_a, 1);
      for (int i = 0; i < 4; i++) idle();

      // Saturation: seven rounds of three stalls each = 21 stall cycles.
      for (int r = 0; r < 7; r++) begin
         wr_cyc(3'd3, 1'b0, (r == 0));
         for (int j = 0; j < 4; j++) rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      idle();
      chk("sat_count_c", cnt_c, 15);
      chk("nosat_count_a", cnt_a, 21);
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      chk("clr_count_c", cnt_c, 0);
      chk("clr_count_a", cnt_a, 0);

      // Clear wins over a same-cycle stall, then reset mid-stall drops stall.
      wr_cyc(3'd3, 1'b0, 1'b0);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("clr_stall_stall", stall_a, 1);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("clr_wins_count", cnt_a, 0);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("count_after_clr", cnt_a, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_stall_comb", stall_a, 1);
      rd_cyc(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst_mid_stall_drop", stall_a, 0);
      chk("rst_mid_stall_enpc", enpc_a, 1);
      chk("rst_mid_stall_count", cnt_a, 0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
